// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters: registered operands out, captured result back with ack/ID.
// Define ALU_SELFTEST_EN to add an idle-time ALU self-test (TEST_ISSUE/TEST_CHECK states, st_fault/st_fail_cnt).
module alu_share_arbiter #(
    parameter int NREQ            = 4,
    parameter int IDW             = 3,
    parameter int SELFTEST_PERIOD = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*32-1:0]   i_req_a,
    input  logic [NREQ*32-1:0]   i_req_b,
    input  logic [NREQ*3-1:0]    i_req_cont,
    output logic [NREQ-1:0]      o_ack,
    output logic                 o_rsp_valid,
    output logic [IDW-1:0]       o_rsp_id,
    output logic [31:0]          o_rsp_result,
    output logic                 o_rsp_zero,
    output logic [31:0]          o_alu_a,
    output logic [31:0]          o_alu_b,
    output logic [2:0]           o_alu_cont,
    input  logic [31:0]          i_alu_result,
    input  logic                 i_alu_zero,
    output logic                 o_busy,
    output logic                 o_st_fault,
    output logic [7:0]           o_st_fail_cnt
);

    localparam int             NREQ_M1 = NREQ - 1;
    localparam logic [IDW:0]   L_NREQ  = NREQ[IDW:0];
    localparam logic [IDW-1:0] L_LAST  = NREQ_M1[IDW-1:0];

    if (NREQ < 2 || NREQ > 8 || (2 ** IDW) < NREQ || SELFTEST_PERIOD < 1) begin : g_bad_param
        $error("alu_share_arbiter: illegal parameter combination");
    end

`ifdef ALU_SELFTEST_EN
    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_EXEC       = 2'd1,
        S_TEST_ISSUE = 2'd2,
        S_TEST_CHECK = 2'd3
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;
`endif

    state_t          r_state;
    state_t          w_next;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_win;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_off;
    logic [IDW:0]    w_sum;
    logic [NREQ-1:0] w_eligible;
    logic [NREQ-1:0] w_rot;
    logic            w_found;
    logic            w_grant;
    logic            w_exec;
    logic [31:0]     w_sel_a;
    logic [31:0]     w_sel_b;
    logic [2:0]      w_sel_cont;

`ifdef ALU_SELFTEST_EN
    localparam int            CW       = $clog2(SELFTEST_PERIOD + 1);
    localparam logic [CW-1:0] L_PERIOD = CW'(SELFTEST_PERIOD);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  cont;
        logic [31:0] result;
        logic        zero;
    } st_vec_t;

    logic [CW-1:0] r_idle_cnt;
    logic [2:0]    r_st_idx;
    logic          w_st_issue;
    logic          w_st_check;
    logic          w_st_last;
    logic          w_mismatch;
    st_vec_t       w_vec;

    function automatic st_vec_t st_vector(input logic [2:0] idx);
        st_vec_t v;
        case (idx)
            3'd0:    v = '{32'd5,        32'd3,        3'b010, 32'd8,        1'b0};
            3'd1:    v = '{32'd7,        32'd7,        3'b110, 32'd0,        1'b1};
            3'd2:    v = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, 1'b0};
            3'd3:    v = '{32'h0F0F0F0F, 32'hF0F0F0F0, 3'b001, 32'hFFFFFFFF, 1'b0};
            3'd4:    v = '{32'd3,        32'd9,        3'b111, 32'd1,        1'b0};
            default: v = '{32'd0,        32'd0,        3'b000, 32'd0,        1'b1};
        endcase
        return v;
    endfunction

    // Current self-test vector and its pass/fail verdict against the live ALU outputs.
    always_comb begin
        w_vec      = st_vector(r_st_idx);
        w_st_last  = (r_st_idx == 3'd4);
        w_mismatch = (i_alu_result != w_vec.result) || (i_alu_zero != w_vec.zero);
    end
`endif

    // Rotate eligibility so the pointer sits at bit 0; the lowest set bit is the winner's offset.
    always_comb begin
        w_eligible = i_req & ~o_ack;
        w_rot      = NREQ'({w_eligible, w_eligible} >> r_ptr);
        w_found    = |w_rot;
        w_off      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_off = w_rot[k] ? IDW'(k) : w_off;
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= L_NREQ) begin
            w_win = IDW'(w_sum - L_NREQ);
        end else begin
            w_win = w_sum[IDW-1:0];
        end
        w_sel_a    = 32'd0;
        w_sel_b    = 32'd0;
        w_sel_cont = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_a    = (w_win == IDW'(i)) ? i_req_a[32*i +: 32]  : w_sel_a;
            w_sel_b    = (w_win == IDW'(i)) ? i_req_b[32*i +: 32]  : w_sel_b;
            w_sel_cont = (w_win == IDW'(i)) ? i_req_cont[3*i +: 3] : w_sel_cont;
        end
    end

    // Next-state decode and per-state action strobes.
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_exec  = 1'b0;
`ifdef ALU_SELFTEST_EN
        w_st_issue = 1'b0;
        w_st_check = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef ALU_SELFTEST_EN
                if (r_idle_cnt == L_PERIOD) begin
                    w_next = S_TEST_ISSUE;
                end else if (w_found) begin
                    w_next  = S_EXEC;
                    w_grant = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
`else
                if (w_found) begin
                    w_next  = S_EXEC;
                    w_grant = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
`endif
            end
            S_EXEC: begin
                w_next = S_IDLE;
                w_exec = 1'b1;
            end
`ifdef ALU_SELFTEST_EN
            S_TEST_ISSUE: begin
                w_next     = S_TEST_CHECK;
                w_st_issue = 1'b1;
            end
            S_TEST_CHECK: begin
                w_st_check = 1'b1;
                w_next     = w_st_last ? S_IDLE : S_TEST_ISSUE;
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant capture, ALU operand drive and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr        <= '0;
            r_win        <= '0;
            o_alu_a      <= 32'd0;
            o_alu_b      <= 32'd0;
            o_alu_cont   <= 3'd0;
            o_ack        <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_id     <= '0;
            o_rsp_result <= 32'd0;
            o_rsp_zero   <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_busy <= (w_next != S_IDLE);
            if (w_grant) begin
                o_alu_a    <= w_sel_a;
                o_alu_b    <= w_sel_b;
                o_alu_cont <= w_sel_cont;
                r_win      <= w_win;
                r_ptr      <= (w_win == L_LAST) ? '0 : w_win + IDW'(1);
            end
`ifdef ALU_SELFTEST_EN
            if (w_st_issue) begin
                o_alu_a    <= w_vec.a;
                o_alu_b    <= w_vec.b;
                o_alu_cont <= w_vec.cont;
            end
`endif
            if (w_exec) begin
                o_rsp_result <= i_alu_result;
                o_rsp_zero   <= i_alu_zero;
                o_ack        <= NREQ'(1) << r_win;
                o_rsp_valid  <= 1'b1;
                o_rsp_id     <= r_win;
            end else begin
                o_ack       <= '0;
                o_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SELFTEST_EN
    // Idle-time counter, vector sequencing and sticky fault accounting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle_cnt    <= '0;
            r_st_idx      <= 3'd0;
            o_st_fault    <= 1'b0;
            o_st_fail_cnt <= 8'd0;
        end else begin
            if (w_grant || (w_st_check && w_st_last)) begin
                r_idle_cnt <= '0;
            end else if ((r_state == S_IDLE) && !w_found && (r_idle_cnt != L_PERIOD)) begin
                r_idle_cnt <= r_idle_cnt + CW'(1);
            end
            if (w_st_check) begin
                r_st_idx <= w_st_last ? 3'd0 : r_st_idx + 3'd1;
                if (w_mismatch) begin
                    o_st_fault <= 1'b1;
                    if (o_st_fail_cnt != 8'hFF) begin
                        o_st_fail_cnt <= o_st_fail_cnt + 8'd1;
                    end
                end
            end
        end
    end
`else
    assign o_st_fault    = 1'b0;
    assign o_st_fail_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU model.
module tb_alu_share_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    i_req;
    logic [NREQ*32-1:0] i_req_a;
    logic [NREQ*32-1:0] i_req_b;
    logic [NREQ*3-1:0]  i_req_cont;
    logic [NREQ-1:0]    o_ack;
    logic               o_rsp_valid;
    logic [IDW-1:0]     o_rsp_id;
    logic [31:0]        o_rsp_result;
    logic               o_rsp_zero;
    logic [31:0]        o_alu_a;
    logic [31:0]        o_alu_b;
    logic [2:0]         o_alu_cont;
    logic [31:0]        alu_result;
    logic               alu_zero;
    logic               o_busy;
    logic               o_st_fault;
    logic [7:0]         o_st_fail_cnt;

    logic [31:0] alu_raw;
    logic        stuck;
    int          checks = 0;
    int          errors = 0;
    int          e;
    int          n;
    int          order [5] = '{0, 1, 2, 3, 0};

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .SELFTEST_PERIOD(64)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_cont(i_req_cont),
        .o_ack(o_ack), .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
        .o_rsp_result(o_rsp_result), .o_rsp_zero(o_rsp_zero),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_cont(o_alu_cont),
        .i_alu_result(alu_result), .i_alu_zero(alu_zero),
        .o_busy(o_busy), .o_st_fault(o_st_fault), .o_st_fail_cnt(o_st_fail_cnt)
    );

    always #5 clk = ~clk;

    // MIPS-style ALU; stuck forces result bit 0 low.
    always_comb begin
        case (o_alu_cont)
            3'b000:  alu_raw = o_alu_a & o_alu_b;
            3'b001:  alu_raw = o_alu_a | o_alu_b;
            3'b010:  alu_raw = o_alu_a + o_alu_b;
            3'b110:  alu_raw = o_alu_a - o_alu_b;
            3'b111:  alu_raw = ($signed(o_alu_a) < $signed(o_alu_b)) ? 32'd1 : 32'd0;
            default: alu_raw = 32'd0;
        endcase
        alu_result = stuck ? (alu_raw & ~32'd1) : alu_raw;
        alu_zero   = (alu_result == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        i_req_a[32*i +: 32] = a;
        i_req_b[32*i +: 32] = b;
        i_req_cont[3*i +: 3] = c;
    endtask

    initial begin
        reset = 1'b1; i_req = '0; i_req_a = '0; i_req_b = '0; i_req_cont = '0; stuck = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", o_ack, 0);
        check("rst_valid", o_rsp_valid, 0);
        check("rst_id", o_rsp_id, 0);
        check("rst_result", o_rsp_result, 0);
        check("rst_zero", o_rsp_zero, 0);
        check("rst_alu_a", o_alu_a, 0);
        check("rst_alu_b", o_alu_b, 0);
        check("rst_alu_cont", o_alu_cont, 0);
        check("rst_busy", o_busy, 0);
        check("rst_st_fault", o_st_fault, 0);
        check("rst_st_cnt", o_st_fail_cnt, 0);
        reset = 1'b0;
        step();
        check("idle_busy", o_busy, 0);

        // Fairness: all four requesting, grant order 0,1,2,3,0, acks two cycles apart.
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(16 * i + 1), 32'(i), 3'b010);
        i_req = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            e = order[g];
            check("fair_alu_a", o_alu_a, 32'(16 * e + 1));
            check("fair_noack", o_ack, 0);
            step();
            check("fair_ack", o_ack, 32'(1 << e));
            check("fair_id", o_rsp_id, 32'(e));
            check("fair_result", o_rsp_result, 32'(17 * e + 1));
            i_req[e] = 1'b0;
            step();
            i_req[e] = 1'b1;
        end
        i_req = '0;
        step();
        check("fair_tail_ack", o_ack, 4'b0010);
        step();

        // Single request from requester 1.
        set_op(1, 32'd5, 32'd3, 3'b010);
        i_req = 4'b0010;
        step();
        check("single_alu_a", o_alu_a, 5);
        check("single_alu_b", o_alu_b, 3);
        check("single_alu_cont", o_alu_cont, 3'b010);
        check("single_busy", o_busy, 1);
        check("single_noack", o_rsp_valid, 0);
        step();
        check("single_ack", o_ack, 4'b0010);
        check("single_valid", o_rsp_valid, 1);
        check("single_id", o_rsp_id, 1);
        check("single_result", o_rsp_result, 8);
        check("single_zero", o_rsp_zero, 0);
        check("single_busy_done", o_busy, 0);
        i_req = '0;
        step();
        check("single_ack_drop", o_ack, 0);
        check("single_valid_drop", o_rsp_valid, 0);
        check("single_result_hold", o_rsp_result, 8);
        check("single_alu_a_hold", o_alu_a, 5);

        // Pointer wrap: after a grant to 3, 0 beats 3.
        set_op(3, 32'd100, 32'd1, 3'b110);
        set_op(0, 32'd20, 32'd22, 3'b010);
        i_req = 4'b1000;
        step();
        step();
        check("wrap_ack3", o_ack, 4'b1000);
        check("wrap_res3", o_rsp_result, 99);
        i_req = '0;
        step();
        i_req = 4'b1001;
        step();
        step();
        check("wrap_ack0", o_ack, 4'b0001);
        check("wrap_id0", o_rsp_id, 0);
        check("wrap_res0", o_rsp_result, 42);
        i_req = 4'b1000;
        step();
        step();
        check("wrap_ack3b", o_ack, 4'b1000);
        i_req = '0;
        step();

        // Zero flag.
        set_op(2, 32'h12345678, 32'h12345678, 3'b110);
        i_req = 4'b0100;
        step();
        step();
        check("zero_id", o_rsp_id, 2);
        check("zero_result", o_rsp_result, 0);
        check("zero_flag", o_rsp_zero, 1);
        i_req = '0;
        step();

        // Undefined alucont is passed through untouched.
        set_op(1, 32'd1, 32'd2, 3'b100);
        i_req = 4'b0010;
        step();
        check("undef_cont", o_alu_cont, 3'b100);
        step();
        check("undef_ack", o_ack, 4'b0010);
        i_req = '0;
        step();

        // Reset during EXEC discards the operation.
        set_op(2, 32'd9, 32'd4, 3'b010);
        i_req = 4'b0100;
        step();
        check("mid_busy", o_busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_ack", o_ack, 0);
        check("mid_rst_valid", o_rsp_valid, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_alu_a", o_alu_a, 0);
        check("mid_rst_result", o_rsp_result, 0);
        step();
        check("mid_rst_hold_ack", o_ack, 0);
        reset = 1'b0;
        step();
        check("mid_after_alu_a", o_alu_a, 9);
        step();
        check("mid_after_ack", o_ack, 4'b0100);
        check("mid_after_result", o_rsp_result, 13);
        i_req = '0;
        step();

`ifdef ALU_SELFTEST_EN
        // Good ALU: one ten-cycle test, no fault.
        for (int c = 0; c < 200 && !o_busy; c++) step();
        check("st1_start", o_busy, 1);
        n = 0;
        while (o_busy && n < 30) begin n++; step(); end
        check("st1_len", n, 10);
        check("st1_fault", o_st_fault, 0);
        check("st1_cnt", o_st_fail_cnt, 0);
        // Stuck bit 0: vectors 4 and 5 fail; a request raised mid-test waits.
        stuck = 1'b1;
        for (int c = 0; c < 200 && !o_busy; c++) step();
        check("st2_start", o_busy, 1);
        set_op(1, 32'd40, 32'd2, 3'b010);
        i_req = 4'b0010;
        n = 0;
        while (o_busy && n < 30) begin
            check("st2_noack", o_rsp_valid, 0);
            n++;
            step();
        end
        check("st2_len", n, 10);
        check("st2_fault", o_st_fault, 1);
        check("st2_cnt", o_st_fail_cnt, 2);
        step();
        check("st2_req_alu_a", o_alu_a, 40);
        step();
        check("st2_req_ack", o_ack, 4'b0010);
        check("st2_req_result", o_rsp_result, 42);
        i_req = '0;
        stuck = 1'b0;
        step();
`else
        // Long idle: no self-test exists, so nothing happens.
        n = 0;
        for (int c = 0; c < 80; c++) begin
            if (o_busy) n++;
            step();
        end
        check("idle_never_busy", n, 0);
        check("idle_st_fault", o_st_fault, 0);
        check("idle_st_cnt", o_st_fail_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
